// File: rtl/fp_div_seq.sv
// Iterative floating-point divider: one restoring quotient bit per cycle,
// round-to-nearest-even, flush-to-zero, special values and exception flags.
module fp_div_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int BIAS  = 127
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   div,
    output logic [4:0]             flags
);

    localparam int W  = EXP_W + MAN_W + 1;
    localparam int EW = EXP_W + 2;
    localparam int QW = MAN_W + 4;
    localparam int RW = MAN_W + 3;
    localparam int CW = $clog2(QW);

    localparam logic signed [EW-1:0] BIAS_E = EW'(BIAS);
    localparam logic signed [EW-1:0] EMAX   = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] ONE    = EW'(1);
    localparam logic signed [EW-1:0] ZERO   = '0;
    localparam logic [CW-1:0]        LAST   = CW'(QW - 1);

    localparam logic [W-1:0] QNAN =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;

    state_t state_q, state_d;

    logic                 sign_q;
    logic signed [EW-1:0] exp_q;
    logic [MAN_W:0]       mb_q;
    logic [RW-1:0]        rem_q;
    logic [QW-1:0]        q_q;
    logic [CW-1:0]        cnt_q;
    logic [W-1:0]         div_q;
    logic [4:0]           flags_q;

    logic                 sa, sb;
    logic [EXP_W-1:0]     ea, eb;
    logic [MAN_W-1:0]     fa, fb;
    logic                 a_zero, a_inf, a_nan, a_snan;
    logic                 b_zero, b_inf, b_nan, b_snan;
    logic                 ss;
    logic signed [EW-1:0] e0;

    assign sa = a[W-1];
    assign ea = a[W-2:MAN_W];
    assign fa = a[MAN_W-1:0];
    assign sb = b[W-1];
    assign eb = b[W-2:MAN_W];
    assign fb = b[MAN_W-1:0];
    assign ss = sa ^ sb;

    // exp=0 covers both zero and flushed subnormals
    assign a_zero = (ea == '0);
    assign a_inf  = (&ea) && (fa == '0);
    assign a_nan  = (&ea) && (fa != '0);
    assign a_snan = a_nan && !fa[MAN_W-1];
    assign b_zero = (eb == '0);
    assign b_inf  = (&eb) && (fb == '0);
    assign b_nan  = (&eb) && (fb != '0);
    assign b_snan = b_nan && !fb[MAN_W-1];

    assign e0 = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS_E;

    logic           spec;
    logic [W-1:0]   spec_res;
    logic [4:0]     spec_flags;

    always_comb begin
        spec       = 1'b1;
        spec_res   = '0;
        spec_flags = '0;
        priority case (1'b1)
            a_nan || b_nan: begin
                spec_res   = QNAN;
                spec_flags = {a_snan | b_snan, 4'b0000};
            end
            (a_zero && b_zero) || (a_inf && b_inf): begin
                spec_res   = QNAN;
                spec_flags = 5'b10000;
            end
            a_inf: spec_res = {ss, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            b_inf: spec_res = {ss, {(W-1){1'b0}}};
            b_zero: begin
                spec_res   = {ss, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                spec_flags = 5'b01000;
            end
            a_zero: spec_res = {ss, {(W-1){1'b0}}};
            default: spec = 1'b0;
        endcase
    end

    logic [RW-1:0] mb_ext, rem_sub, rem_nxt;
    logic          ge;

    assign mb_ext  = {2'b00, mb_q};
    assign ge      = (rem_q >= mb_ext);
    assign rem_sub = ge ? rem_q - mb_ext : rem_q;
    assign rem_nxt = {rem_sub[RW-2:0], 1'b0};

    logic [QW-1:0]        qn;
    logic signed [EW-1:0] en, ef;
    logic                 lsb, grd, rnd, stk, inc, carry;
    logic [MAN_W+1:0]     mr;
    logic [MAN_W-1:0]     frac_r;
    logic [W-1:0]         rnd_res;
    logic [4:0]           rnd_flags;

    always_comb begin
        qn  = q_q[QW-1] ? q_q : {q_q[QW-2:0], 1'b0};
        en  = q_q[QW-1] ? exp_q : exp_q - ONE;
        lsb = qn[3];
        grd = qn[2];
        rnd = qn[1];
        stk = qn[0] | (|rem_q);
        inc = grd & (rnd | stk | lsb);
        mr  = {1'b0, qn[QW-1:3]} + {{(MAN_W+1){1'b0}}, inc};
        carry  = mr[MAN_W+1];
        ef     = carry ? en + ONE : en;
        frac_r = carry ? mr[MAN_W:1] : mr[MAN_W-1:0];
        rnd_res   = {sign_q, ef[EXP_W-1:0], frac_r};
        rnd_flags = {4'b0000, grd | rnd | stk};
        if (ef >= EMAX) begin
            rnd_res   = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            rnd_flags = 5'b00101;
        end else if (ef <= ZERO) begin
            rnd_res   = {sign_q, {(W-1){1'b0}}};
            rnd_flags = 5'b00011;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = spec ? DONE : DIV;
            end
            DIV:   if (cnt_q == LAST) state_d = ROUND;
            ROUND: state_d = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sign_q  <= 1'b0;
            exp_q   <= '0;
            mb_q    <= '0;
            rem_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            div_q   <= '0;
            flags_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid && spec) begin
                        div_q   <= spec_res;
                        flags_q <= spec_flags;
                    end else if (in_valid) begin
                        sign_q <= ss;
                        exp_q  <= e0;
                        mb_q   <= {1'b1, fb};
                        rem_q  <= {2'b01, fa};
                        q_q    <= '0;
                        cnt_q  <= '0;
                    end
                end
                DIV: begin
                    rem_q <= rem_nxt;
                    q_q   <= {q_q[QW-2:0], ge};
                    cnt_q <= cnt_q + CW'(1);
                end
                ROUND: begin
                    div_q   <= rnd_res;
                    flags_q <= rnd_flags;
                end
                default: ;
            endcase
        end
    end

    assign div   = div_q;
    assign flags = flags_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// Bench for fp_div_seq: vector table plus backpressure, reset-abort
// and half-precision sequences, checked through an expected-result queue.
module tb_fp_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, div;
    logic [4:0]  flags;
    logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
    logic [15:0] h_a, h_b, h_div;
    logic [4:0]  h_flags;

    always #5 clk = ~clk;

    fp_div_seq dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .div(div), .flags(flags)
    );

    fp_div_seq #(.EXP_W(5), .MAN_W(10), .BIAS(15)) dut_h (
        .clk(clk), .rst(rst),
        .in_valid(h_in_valid), .in_ready(h_in_ready),
        .a(h_a), .b(h_b),
        .out_valid(h_out_valid), .out_ready(h_out_ready),
        .div(h_div), .flags(h_flags)
    );

    typedef struct {
        logic [31:0] d;
        logic [4:0]  f;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic [4:0]  f;
        int          lat;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[16];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    // Called just after a rising edge; returns just after the accept edge.
    task automatic issue(input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] dv, input logic [4:0] fv,
                         input string nm);
        exp_t e;
        in_valid = 1'b1;
        a = av;
        b = bv;
        @(negedge clk);
        chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e.d = dv;
        e.f = fv;
        sb_q.push_back(e);
    endtask

    // Waits for out_valid (bounded), checks latency, pops and compares.
    task automatic collect(input int lat_exp, input string nm);
        int   lat = 0;
        bit   busy_bad = 1'b0;
        exp_t e;
        do begin
            @(negedge clk);
            lat++;
            if (!out_valid && in_ready) busy_bad = 1'b1;
        end while (!out_valid && lat < 200);
        chk({nm, " latency"}, 32'(lat), 32'(lat_exp));
        chk({nm, " busy"}, 32'(busy_bad | in_ready), 32'd0);
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got result expected empty queue", nm);
        end else begin
            e = sb_q.pop_front();
            chk({nm, " div"}, div, e.d);
            chk({nm, " flags"}, 32'(flags), 32'(e.f));
        end
    endtask

    initial begin
        vecs[0]  = '{"6/2",      32'h40C00000, 32'h40000000,
                     32'h40400000, 5'b00000, 29};
        vecs[1]  = '{"1/3",      32'h3F800000, 32'h40400000,
                     32'h3EAAAAAB, 5'b00001, 29};
        vecs[2]  = '{"-1/3",     32'hBF800000, 32'h40400000,
                     32'hBEAAAAAB, 5'b00001, 29};
        vecs[3]  = '{"1/0",      32'h3F800000, 32'h00000000,
                     32'h7F800000, 5'b01000, 1};
        vecs[4]  = '{"0/0",      32'h00000000, 32'h00000000,
                     32'h7FC00000, 5'b10000, 1};
        vecs[5]  = '{"inf/inf",  32'h7F800000, 32'h7F800000,
                     32'h7FC00000, 5'b10000, 1};
        vecs[6]  = '{"ovf",      32'h7F000000, 32'h3E800000,
                     32'h7F800000, 5'b00101, 29};
        vecs[7]  = '{"unf",      32'h00800000, 32'h4B000000,
                     32'h00000000, 5'b00011, 29};
        vecs[8]  = '{"snan/1",   32'h7F800001, 32'h3F800000,
                     32'h7FC00000, 5'b10000, 1};
        vecs[9]  = '{"qnan/0",   32'h7FC00000, 32'h00000000,
                     32'h7FC00000, 5'b00000, 1};
        vecs[10] = '{"-inf/2",   32'hFF800000, 32'h40000000,
                     32'hFF800000, 5'b00000, 1};
        vecs[11] = '{"1/-inf",   32'h3F800000, 32'hFF800000,
                     32'h80000000, 5'b00000, 1};
        vecs[12] = '{"-0/3",     32'h80000000, 32'h40400000,
                     32'h80000000, 5'b00000, 1};
        vecs[13] = '{"sub/1",    32'h00000001, 32'h3F800000,
                     32'h00000000, 5'b00000, 1};
        vecs[14] = '{"3/1.5",    32'h40400000, 32'h3FC00000,
                     32'h40000000, 5'b00000, 29};
        vecs[15] = '{"2/3",      32'h40000000, 32'h40400000,
                     32'h3F2AAAAB, 5'b00001, 29};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        h_in_valid = 1'b0;
        h_out_ready = 1'b1;
        h_a = '0;
        h_b = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst div", div, 32'd0);
        chk("rst flags", 32'(flags), 32'd0);
        chk("rst h_in_ready", 32'(h_in_ready), 32'd1);

        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].f, vecs[i].name);
            collect(vecs[i].lat, vecs[i].name);
            @(posedge clk);
            #1;
        end

        // operands offered while busy must be ignored
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 5'b0, "busy_in");
        in_valid = 1'b1;
        a = 32'h3F800000;
        b = 32'h00000000;
        repeat (5) @(posedge clk);
        #1;
        in_valid = 1'b0;
        collect(24, "busy_in");
        @(posedge clk);
        #1;

        // backpressure
        out_ready = 1'b0;
        issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, "bp");
        collect(29, "bp");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp hold valid", 32'(out_valid), 32'd1);
            chk("bp hold div", div, 32'h3EAAAAAB);
            chk("bp hold flags", 32'(flags), 32'd1);
            chk("bp hold in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp release in_ready", 32'(in_ready), 32'd1);
        chk("bp release out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 5'b0, "bp2");
        collect(29, "bp2");
        @(posedge clk);
        #1;

        // reset during the iteration phase aborts the operation
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 5'b0, "abort");
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        void'(sb_q.pop_back());
        @(negedge clk);
        chk("abort out_valid", 32'(out_valid), 32'd0);
        chk("abort in_ready", 32'(in_ready), 32'd1);
        chk("abort div", div, 32'd0);
        chk("abort flags", 32'(flags), 32'd0);
        @(posedge clk);
        #1;
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 5'b0, "after_abort");
        collect(29, "after_abort");
        @(posedge clk);
        #1;

        // half precision instance
        begin
            int   lat = 0;
            exp_t e;
            h_in_valid = 1'b1;
            h_a = 16'h4600;
            h_b = 16'h4000;
            @(negedge clk);
            chk("half in_ready", 32'(h_in_ready), 32'd1);
            @(posedge clk);
            #1;
            h_in_valid = 1'b0;
            e.d = 32'h00004200;
            e.f = 5'b00000;
            sb_q.push_back(e);
            do begin
                @(negedge clk);
                lat++;
            end while (!h_out_valid && lat < 200);
            chk("half latency", 32'(lat), 32'd16);
            e = sb_q.pop_front();
            chk("half div", {16'h0, h_div}, e.d);
            chk("half flags", 32'(h_flags), 32'(e.f));
            @(posedge clk);
            #1;
        end

        chk("queue drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp_div_seq.md
Name: fp_div_seq

Overview:
- Parametrised, iterative IEEE-754 style floating-point divider (a / b) with valid/ready handshakes on input and output.
- Successor to the combinational single-precision divider. Adds:
  - generic exponent and mantissa widths;
  - a one-quotient-bit-per-cycle mantissa datapath;
  - round-to-nearest-even;
  - special-value handling and exception flags.
- Sits between operand-issue logic and a result-writeback stage in the FP datapath.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored fraction width (hidden bit not counted).
- BIAS, 127, exponent bias; must equal 2^(EXP_W-1)-1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands a, b present.
- in_ready  out  1  block can accept operands.
- a  in  EXP_W+MAN_W+1  dividend {sign, exp, frac}.
- b  in  EXP_W+MAN_W+1  divisor, same format.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  downstream accepts the result.
- div  out  EXP_W+MAN_W+1  quotient.
- flags  out  5  {invalid, div_by_zero, overflow, underflow, inexact}.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; in_ready=1; out_valid=0; div=0; flags=0.
  - All datapath registers cleared.
  - Reset mid-operation aborts the division; no result is produced.
- FSM states: IDLE, DIV, ROUND, DONE.
  - IDLE: in_ready=1. On in_valid&in_ready, latch operands:
    - if a special case applies, go to DONE;
    - else go to DIV.
  - DIV: runs exactly MAN_W+4 cycles under an iteration counter.
    - Each cycle is one radix-2 restoring step on {1,frac_a} / {1,frac_b}.
    - The partial remainder is MAN_W+3 bits wide.
    - After the last step, go to ROUND.
  - ROUND: one cycle covering normalize, round, exponent check, and packing into the output register. Then go to DONE.
  - DONE: out_valid=1.
    - div and flags are held stable until out_ready=1.
    - On out_valid&out_ready, go to IDLE.
    - in_ready rises the following cycle; there is no same-cycle re-accept.
- in_ready=0 in every state except IDLE.
- Latency:
  - Normal path: accept edge to first out_valid cycle = MAN_W+6 cycles.
  - Special-case path: 1 cycle.
- Arithmetic:
  - Quotient q has MAN_W+4 bits and lies in (0.5, 2).
  - If q MSB=0, shift q left 1 and decrement the exponent.
  - Exponent uses EXP_W+2-bit signed arithmetic: e = ea - eb + BIAS (then any normalize adjustment).
  - Rounding bits:
    - guard = next bit below the LSB;
    - round = bit below guard;
    - sticky = OR of the remaining q bits OR (final remainder != 0).
  - RNE increments when guard & (round | sticky | lsb).
  - A mantissa carry-out renormalizes and increments e.
  - inexact = guard | round | sticky.
- Exponent range:
  - e >= 2^EXP_W-1: result = signed infinity; overflow=1, inexact=1.
  - e <= 0: result = signed zero (flush to zero, no subnormal output); underflow=1, inexact=1.
- Inputs with exp=0 are treated as zero; subnormal inputs are flushed.
- Special cases, in priority order (sign = sa^sb unless stated):
  1. Either operand NaN → canonical qNaN {0, all-ones exp, frac MSB=1, rest 0}; invalid=1 only if that NaN is signalling.
  2. 0/0 or inf/inf → qNaN, invalid=1.
  3. inf/x → signed inf.
  4. x/inf → signed zero.
  5. x/0 (x finite, non-zero) → signed inf, div_by_zero=1.
  6. 0/x → signed zero.
- Flags for the special-case results are exactly those listed above; all other flag bits are 0.
- in_valid asserted outside IDLE is ignored; the operands are not latched.

Test Plan:
- Default params: a=0x40C00000 (6.0), b=0x40000000 (2.0) → div=0x40400000, flags=0; out_valid exactly 29 cycles after accept; in_ready=0 throughout.
- a=0x3F800000, b=0x40400000 (1/3) → div=0x3EAAAAAB, flags=00001. Also a=0xBF800000, b=0x40400000 → div=0xBEAAAAAB.
- Specials, each with out_valid 1 cycle after accept:
  - 0x3F800000/0x00000000 → 0x7F800000, flags=01000.
  - 0x00000000/0x00000000 → 0x7FC00000, flags=10000.
  - 0x7F800000/0x7F800000 → 0x7FC00000, flags=10000.
- Range limits:
  - 0x7F000000/0x3E800000 → 0x7F800000, flags=00101.
  - 0x00800000/0x4B000000 → 0x00000000, flags=00011.
- Back-to-back and backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid; div and flags stay stable and in_ready=0.
  - Release out_ready; next cycle in_ready=1; a second operation then completes correctly.
- Reset at DIV iteration 10:
  - Next cycle: out_valid=0, in_ready=1, div=0.
  - A new 6.0/2.0 request then returns 0x40400000 after 29 cycles.
- Half-precision config (EXP_W=5, MAN_W=10, BIAS=15): 0x4600/0x4000 → 0x4200, latency 16 cycles.
